// File: rtl/matrix_cmd_seq_if.sv
// CPU register-window bus of the MADAM matrix command sequencer.
// The master drives the strobes and data; the slave returns read data and status.
interface matrix_cmd_seq_if #(
  parameter int ADDR_W = 8
);
  logic              cpu_sel;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_din;
  logic [31:0]       cpu_dout;
  logic              cpu_rvalid;
  logic              busy;
  logic              done;

  modport master (
    output cpu_sel, cpu_wr, cpu_rd, cpu_addr, cpu_din,
    input  cpu_dout, cpu_rvalid, busy, done
  );

  modport slave (
    input  cpu_sel, cpu_wr, cpu_rd, cpu_addr, cpu_din,
    output cpu_dout, cpu_rvalid, busy, done
  );
endinterface

// File: rtl/matrix_cmd_seq.sv
// MADAM matrix unit front end: MI/MV/MO register window plus a MAC sequencer.
// Each command first publishes the previous results (tmpMO) to MO, then recomputes tmpMO.
module matrix_cmd_seq #(
  parameter int FRAC_BITS = 16,
  parameter int ADDR_W    = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  matrix_cmd_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_STORE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mi_q [16];
  logic [31:0] mi_d [16];
  logic [31:0] mv_q [4];
  logic [31:0] mv_d [4];
  logic [31:0] tmp_q [4];
  logic [31:0] tmp_d [4];
  logic [31:0] mo_q [4];
  logic [31:0] mo_d [4];
  logic [63:0] acc_q, acc_d;
  logic [1:0]  r_q, r_d, c_q, c_d;
  logic        n3_q, n3_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic [31:0] dout_q, dout_d;
  logic        rvalid_q, rvalid_d;

  logic [ADDR_W-1:0] word_s;
  logic              wr_s, rd_s;
  logic              is_mi_s, is_mv_s, is_mo_s, is_status_s, is_cmd_s, cmd_ok_s;
  logic [3:0]        mi_idx_s;
  logic [1:0]        vec_idx_s, last_s;
  logic [31:0]       mi_op_s, mv_op_s, rdata_s;
  logic [63:0]       op_a_s, op_b_s, prod_s;

  // Word-granular decode; the byte-lane bits drop out of the shift.
  assign word_s      = bus.cpu_addr >> 2;
  assign wr_s        = bus.cpu_sel & bus.cpu_wr;
  assign rd_s        = bus.cpu_sel & bus.cpu_rd & ~bus.cpu_wr;
  assign is_mi_s     = (word_s < ADDR_W'(16));
  assign is_mv_s     = (word_s >= ADDR_W'(16)) && (word_s <= ADDR_W'(19));
  assign is_mo_s     = (word_s >= ADDR_W'(24)) && (word_s <= ADDR_W'(27));
  assign is_status_s = (word_s == ADDR_W'(62));
  assign is_cmd_s    = (word_s == ADDR_W'(63));
  assign mi_idx_s    = 4'(word_s);
  assign vec_idx_s   = 2'(word_s);
  assign cmd_ok_s    = wr_s & is_cmd_s & ~busy_q &
                       ((bus.cpu_din == 32'd0) || (bus.cpu_din == 32'd1));
  assign last_s      = n3_q ? 2'd2 : 2'd3;

  // The single shared multiplier: live operands, one 64-bit product per MAC cycle.
  assign mi_op_s = mi_q[{r_q, c_q}];
  assign mv_op_s = mv_q[c_q];
  assign op_a_s  = {{32{mi_op_s[31]}}, mi_op_s};
  assign op_b_s  = {{32{mv_op_s[31]}}, mv_op_s};
  assign prod_s  = op_a_s * op_b_s;

  assign bus.cpu_dout   = dout_q;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Read data multiplexer for the register window.
  always_comb begin
    rdata_s = 32'd0;
    if (is_mi_s) begin
      rdata_s = mi_q[mi_idx_s];
    end else if (is_mv_s) begin
      rdata_s = mv_q[vec_idx_s];
    end else if (is_mo_s) begin
      rdata_s = mo_q[vec_idx_s];
    end else if (is_status_s) begin
      rdata_s = {30'd0, overrun_q, busy_q};
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Sequencer next state plus CPU register-write and read handling.
  always_comb begin
    state_d   = state_q;
    mi_d      = mi_q;
    mv_d      = mv_q;
    tmp_d     = tmp_q;
    mo_d      = mo_q;
    acc_d     = acc_q;
    r_d       = r_q;
    c_d       = c_q;
    n3_d      = n3_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    dout_d    = dout_q;
    rvalid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_ok_s) begin
          mo_d    = tmp_q;
          acc_d   = 64'd0;
          r_d     = 2'd0;
          c_d     = 2'd0;
          n3_d    = bus.cpu_din[0];
          busy_d  = 1'b1;
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + prod_s;
        if (c_q == last_s) begin
          state_d = ST_STORE;
        end else begin
          c_d = c_q + 2'd1;
        end
      end
      ST_STORE: begin
        tmp_d[r_q] = acc_q[FRAC_BITS+31:FRAC_BITS];
        acc_d      = 64'd0;
        c_d        = 2'd0;
        if (r_q == last_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          r_d     = r_q + 2'd1;
          state_d = ST_MAC;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Operands stay frozen while busy; any attempt to change them is flagged.
    if (rd_s) begin
      rvalid_d = 1'b1;
      dout_d   = rdata_s;
      if (is_status_s) begin
        overrun_d = 1'b0;
      end else begin
        overrun_d = overrun_q;
      end
    end else begin
      rvalid_d = 1'b0;
    end

    if (wr_s) begin
      if (is_mi_s) begin
        if (busy_q) begin
          overrun_d = 1'b1;
        end else begin
          mi_d[mi_idx_s] = bus.cpu_din;
        end
      end else if (is_mv_s) begin
        if (busy_q) begin
          overrun_d = 1'b1;
        end else begin
          mv_d[vec_idx_s] = bus.cpu_din;
        end
      end else if (is_cmd_s && busy_q) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_d;
      end
    end else begin
      overrun_d = overrun_d;
    end
  end

  // State registers; reset aborts any sequence without writeback.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mi_q      <= '{default: 32'd0};
      mv_q      <= '{default: 32'd0};
      tmp_q     <= '{default: 32'd0};
      mo_q      <= '{default: 32'd0};
      acc_q     <= 64'd0;
      r_q       <= 2'd0;
      c_q       <= 2'd0;
      n3_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      dout_q    <= 32'd0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mi_q      <= mi_d;
      mv_q      <= mv_d;
      tmp_q     <= tmp_d;
      mo_q      <= mo_d;
      acc_q     <= acc_d;
      r_q       <= r_d;
      c_q       <= c_d;
      n3_q      <= n3_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      dout_q    <= dout_d;
      rvalid_q  <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_matrix_cmd_seq.sv
// Directed bench for matrix_cmd_seq: copy semantics, fixed point, 3x3 mode,
// overrun, invalid accesses and mid-sequence reset, with hand-computed values.
module tb_matrix_cmd_seq;

  logic clock = 1'b0;
  logic reset_n;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  matrix_cmd_seq_if #(.ADDR_W(8)) bus ();

  matrix_cmd_seq #(.FRAC_BITS(16), .ADDR_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clock);
    bus.cpu_sel  = 1'b1;
    bus.cpu_wr   = 1'b1;
    bus.cpu_addr = addr;
    bus.cpu_din  = data;
    @(negedge clock);
    bus.cpu_sel  = 1'b0;
    bus.cpu_wr   = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clock);
    bus.cpu_sel  = 1'b1;
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = addr;
    @(negedge clock);
    check_val({tag, "_rvalid"}, {31'd0, bus.cpu_rvalid}, 32'd1);
    check_val(tag, bus.cpu_dout, exp);
    bus.cpu_sel  = 1'b0;
    bus.cpu_rd   = 1'b0;
  endtask

  // Issue a command and measure how many cycles busy stays high and how often done pulses.
  task automatic run_cmd(input logic [31:0] cmd, input int exp_len, input string tag);
    int cyc;
    int dn;
    cyc = 0;
    dn  = 0;
    cpu_write(8'hFC, cmd);
    while (bus.busy && cyc < 200) begin
      cyc++;
      if (bus.done) dn++;
      @(negedge clock);
    end
    repeat (2) begin
      if (bus.done) dn++;
      @(negedge clock);
    end
    check_val({tag, "_busy_len"}, 32'(cyc), 32'(exp_len));
    check_val({tag, "_done_cnt"}, 32'(dn), (exp_len == 0) ? 32'd0 : 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clock);
    end
    check_val(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  logic [31:0] mv_init [4];

  initial begin
    mv_init[0] = 32'h0002_0000;
    mv_init[1] = 32'h0003_0000;
    mv_init[2] = 32'h0004_0000;
    mv_init[3] = 32'h0005_0000;
    bus.cpu_sel  = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_rd   = 1'b0;
    bus.cpu_addr = 8'h00;
    bus.cpu_din  = 32'd0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clock);
    check_val("rst_dout",   bus.cpu_dout, 32'd0);
    check_val("rst_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    check_val("rst_busy",   {31'd0, bus.busy}, 32'd0);
    check_val("rst_done",   {31'd0, bus.done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: identity matrix, first command publishes the zero tmpMO
    for (int i = 0; i < 4; i++) begin
      cpu_write(8'(8'h14 * i), 32'h0001_0000);
      cpu_write(8'(8'h40 + 4 * i), mv_init[i]);
    end
    run_cmd(32'd0, 20, "t1_mul4");
    for (int i = 0; i < 4; i++) cpu_read(8'(8'h60 + 4 * i), 32'd0, $sformatf("t1_mo%0d_zero", i));
    run_cmd(32'd1, 12, "t1_mul3");
    for (int i = 0; i < 4; i++) cpu_read(8'(8'h60 + 4 * i), mv_init[i], $sformatf("t1_mo%0d", i));

    // 2: signed 16.16: -1.0*1.5 + 0.5*4.0 = +0.5
    cpu_write(8'h00, 32'hFFFF_0000);
    cpu_write(8'h04, 32'h0000_8000);
    cpu_write(8'h14, 32'd0);
    cpu_write(8'h28, 32'd0);
    cpu_write(8'h3C, 32'd0);
    cpu_write(8'h40, 32'h0001_8000);
    cpu_write(8'h44, 32'h0004_0000);
    cpu_write(8'h48, 32'd0);
    cpu_write(8'h4C, 32'd0);
    run_cmd(32'd1, 12, "t2_a");
    run_cmd(32'd1, 12, "t2_b");
    cpu_read(8'h60, 32'h0000_8000, "t2_mo0");
    cpu_read(8'h64, 32'd0, "t2_mo1");
    cpu_read(8'h68, 32'd0, "t2_mo2");
    cpu_read(8'h6C, 32'h0005_0000, "t2_mo3_kept");

    // 3: 3x3 commands leave tmpMO3 untouched
    cpu_write(8'h3C, 32'h0001_0000);
    cpu_write(8'h4C, 32'h0007_0000);
    run_cmd(32'd0, 20, "t3_mul4");
    run_cmd(32'd1, 12, "t3_a");
    run_cmd(32'd1, 12, "t3_b");
    cpu_read(8'h6C, 32'h0007_0000, "t3_mo3");
    cpu_read(8'h60, 32'h0000_8000, "t3_mo0");

    // 4: write during busy is dropped and sets sticky overrun
    cpu_write(8'hFC, 32'd0);
    cpu_write(8'h00, 32'h1234_5678);
    cpu_read(8'hF8, 32'h0000_0003, "t4_status1");
    cpu_read(8'hF8, 32'h0000_0001, "t4_status2");
    wait_idle("t4_idle");
    cpu_read(8'h00, 32'hFFFF_0000, "t4_mi00");

    // 5: invalid command, unmapped and read-only offsets
    run_cmd(32'd5, 0, "t5_cmd5");
    cpu_write(8'h90, 32'h1234_5678);
    cpu_read(8'h90, 32'd0, "t5_unmapped");
    cpu_write(8'h60, 32'hDEAD_BEEF);
    cpu_read(8'h60, 32'h0000_8000, "t5_mo0");
    cpu_read(8'h6C, 32'h0007_0000, "t5_mo3");
    cpu_read(8'hFC, 32'd0, "t5_cmd_rd");
    cpu_read(8'hF8, 32'd0, "t5_status");

    // 6: asynchronous reset in the middle of a mul4x4
    cpu_write(8'hFC, 32'd0);
    repeat (6) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_val("t6_busy", {31'd0, bus.busy}, 32'd0);
    check_val("t6_done", {31'd0, bus.done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cpu_read(8'h60, 32'd0, "t6_mo0");
    cpu_read(8'h6C, 32'd0, "t6_mo3");
    cpu_read(8'h00, 32'd0, "t6_mi00");
    cpu_read(8'h4C, 32'd0, "t6_mv3");
    run_cmd(32'd0, 20, "t6_mul4");
    cpu_read(8'h60, 32'd0, "t6_tmp0");
    cpu_read(8'h6C, 32'd0, "t6_tmp3");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
